alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Decode-and-issue stage that feeds the shared RV32I `alu` block: it drives `operand1`, `operand2`, `func3` and `subsra` into the ALU and captures `result`.
- Accepts OP (0110011) and OP-IMM (0010011) instructions with register-file values over a valid/ready input.
- Decodes and registers the ALU controls, then registers the ALU result with destination info on a valid/ready output.
- Two-stage elastic pipeline (D = decode register, W = writeback register) with full throughput and backpressure.

Parameters:
XLEN, 32, datapath width; only 32 supported (matches `alu`).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush
in_valid  in  1  instruction offered
in_ready  out  1  stage can accept
instr  in  32  instruction word
rs1_val  in  XLEN  rs1 register value
rs2_val  in  XLEN  rs2 register value
operand1  out  XLEN  to alu.operand1 (D register)
operand2  out  XLEN  to alu.operand2 (D register)
func3  out  3  to alu.func3 (D register)
subsra  out  1  to alu.subsra (D register)
alu_result  in  XLEN  from alu.result (combinational from D)
out_valid  out  1  result available (W valid)
out_ready  in  1  consumer accepts result
out_result  out  XLEN  registered result
out_rd  out  5  destination register instr[11:7]
out_we  out  1  write enable: !illegal && rd!=0
out_illegal  out  1  instruction not a legal OP/OP-IMM

Behaviour:
- Reset (async assert, sync release): d_valid=0, w_valid=0. All D/W registers = 0: operand1, operand2, func3, subsra, out_result, out_rd, out_we, out_illegal. in_ready=0 while rst_n low.
- Handshakes:
  - w_free = !w_valid || out_ready.
  - in_ready = rst_n && !flush && (!d_valid || w_free).
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Pipeline:
  - D loads on input transfer.
  - D→W moves when d_valid && w_free: out_result <= illegal ? 0 : alu_result; rd, we and illegal move with it.
  - d_valid clears when D advances with no new input.
  - Latency: instruction accepted at edge k gives out_valid high after edge k+1.
  - 1 instr/cycle sustained when out_ready=1. No loss, duplication or reordering under any stall pattern.
  - D and W registers hold their values while stalled.
- Decode, OP:
  - operand1=rs1_val, operand2=rs2_val, func3=instr[14:12], subsra=instr[30].
  - funct7 0000000 is legal for all func3.
  - funct7 0100000 is legal only for func3 000 (SUB) and 101 (SRA).
  - Any other funct7 is illegal.
- Decode, OP-IMM:
  - operand1=rs1_val.
  - func3 001/101: operand2 = zero-extended instr[24:20]. func3 001 requires instr[31:25]=0000000. func3 101 requires instr[31:25] = 0000000 or 0100000. subsra=instr[30] for 101, else 0.
  - Other func3: operand2 = sign-extended instr[31:20], subsra=0. ADDI with imm bit 10 set must NOT subtract.
- Illegal instruction (any other opcode or violated funct7):
  - Still flows through the pipeline.
  - D controls: operand1=operand2=0, func3=000, subsra=0.
  - W outputs: out_illegal=1, out_we=0, out_result=0, out_rd=instr[11:7].
- flush:
  - Next edge clears d_valid and w_valid; data registers are don't-care.
  - Flush has priority over a simultaneous input or output transfer; no input is accepted in that cycle.
- Reset mid-stream: all in-flight instructions are discarded immediately; out_valid=0 without waiting for a clock edge.
- Arithmetic is performed by `alu`; this block adds no width extension. Overflow wraps modulo 2^32.

Test Plan:
1. SUB x3,x1,x2 (0x402081B3), rs1=32, rs2=30 -> cycle after accept: func3=000, subsra=1; next: out_valid=1, out_result=2, out_rd=3, out_we=1.
2. ADDI x5,x1,-6 (0xFFA08293), rs1=14 -> operand2=0xFFFFFFFA, subsra=0, out_result=8. ADDI x1,x1,0x400 (0x40008093), rs1=5 -> subsra=0, out_result=1029.
3. SRAI x6,x1,2 (0x4020D313), rs1=0xFFFFFFE8 -> operand2=2, func3=101, subsra=1, out_result=0xFFFFFFFA.
4. Backpressure: 4 back-to-back ADDs with out_ready=0 for 3 cycles -> in_ready falls after 2 accepts; all 4 results emerge in order, no duplicates; throughput 1/cycle after release.
5. Illegal: 0x020080B3 (MUL) and 0x0000007F -> out_illegal=1, out_we=0, out_result=0; ALU inputs all zero. Instruction with rd=x0 -> out_we=0, out_illegal=0.
6. flush and rst_n pulse with both stages full -> out_valid=0 (immediately for reset, next edge for flush); next accepted instruction completes normally with 2-edge latency.

Source files
------------

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I OP/OP-IMM decode-and-issue stage driving a shared alu.
// Two-stage elastic pipeline: D register feeds the alu, W register holds the result.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic [XLEN-1:0] operand1,
    output logic [XLEN-1:0] operand2,
    output logic [2:0]      func3,
    output logic            subsra,
    input  logic [XLEN-1:0] alu_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic            r_d_valid;
    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    logic [2:0]      r_f3;
    logic            r_sub;
    logic [4:0]      r_d_rd;
    logic            r_d_we;
    logic            r_d_ill;

    logic            r_w_valid;
    logic [XLEN-1:0] r_res;
    logic [4:0]      r_w_rd;
    logic            r_w_we;
    logic            r_w_ill;

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [4:0]      w_rd;
    logic            w_legal;
    logic            w_we;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic [2:0]      w_f3_d;
    logic            w_sub;
    logic            w_w_free;
    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_d_adv;
    logic            w_unused;

    assign w_opcode = instr[6:0];
    assign w_f3     = instr[14:12];
    assign w_f7     = instr[31:25];
    assign w_rd     = instr[11:7];
    // Register-number fields are resolved upstream; only the values arrive here.
    assign w_unused = ^instr[19:15];

    always_comb begin
        w_legal = 1'b0;
        w_op1   = '0;
        w_op2   = '0;
        w_f3_d  = 3'b000;
        w_sub   = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_legal = (w_f7 == F7_ZERO) ||
                          ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
                if (w_legal) begin
                    w_op1  = rs1_val;
                    w_op2  = rs2_val;
                    w_f3_d = w_f3;
                    w_sub  = instr[30];
                end
            end
            OPC_OP_IMM: begin
                case (w_f3)
                    3'b001:  w_legal = (w_f7 == F7_ZERO);
                    3'b101:  w_legal = (w_f7 == F7_ZERO) || (w_f7 == F7_ALT);
                    default: w_legal = 1'b1;
                endcase
                if (w_legal) begin
                    w_op1  = rs1_val;
                    w_f3_d = w_f3;
                    // ADDI with imm[10] set must stay an add, so only shifts take instr[30].
                    if ((w_f3 == 3'b001) || (w_f3 == 3'b101)) begin
                        w_op2 = {{(XLEN-5){1'b0}}, instr[24:20]};
                        w_sub = (w_f3 == 3'b101) && instr[30];
                    end else begin
                        w_op2 = {{(XLEN-12){instr[31]}}, instr[31:20]};
                    end
                end
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_we       = w_legal && (w_rd != 5'd0);
    assign w_w_free   = !r_w_valid || out_ready;
    assign in_ready   = rst_n && !flush && (!r_d_valid || w_w_free);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_w_valid && out_ready;
    assign w_d_adv    = r_d_valid && w_w_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_valid <= 1'b0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_f3      <= 3'b000;
            r_sub     <= 1'b0;
            r_d_rd    <= 5'd0;
            r_d_we    <= 1'b0;
            r_d_ill   <= 1'b0;
        end else if (flush) begin
            r_d_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_d_valid <= 1'b1;
            r_op1     <= w_op1;
            r_op2     <= w_op2;
            r_f3      <= w_f3_d;
            r_sub     <= w_sub;
            r_d_rd    <= w_rd;
            r_d_we    <= w_we;
            r_d_ill   <= !w_legal;
        end else if (w_d_adv) begin
            r_d_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_valid <= 1'b0;
            r_res     <= '0;
            r_w_rd    <= 5'd0;
            r_w_we    <= 1'b0;
            r_w_ill   <= 1'b0;
        end else if (flush) begin
            r_w_valid <= 1'b0;
        end else if (w_d_adv) begin
            r_w_valid <= 1'b1;
            r_res     <= r_d_ill ? '0 : alu_result;
            r_w_rd    <= r_d_rd;
            r_w_we    <= r_d_we;
            r_w_ill   <= r_d_ill;
        end else if (w_out_fire) begin
            r_w_valid <= 1'b0;
        end
    end

    assign operand1    = r_op1;
    assign operand2    = r_op2;
    assign func3       = r_f3;
    assign subsra      = r_sub;
    assign out_valid   = r_w_valid;
    assign out_result  = r_res;
    assign out_rd      = r_w_rd;
    assign out_we      = r_w_we;
    assign out_illegal = r_w_ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage with an alu stand-in.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [2:0]  func3;
    logic        subsra;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_illegal;

    always #5 clk = ~clk;

    alu_issue_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .operand1(operand1), .operand2(operand2), .func3(func3), .subsra(subsra),
        .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal)
    );

    // Stand-in for the shared alu block
    always_comb begin
        alu_result = '0;
        case (func3)
            3'd0: alu_result = subsra ? operand1 - operand2 : operand1 + operand2;
            3'd1: alu_result = operand1 << operand2[4:0];
            3'd2: alu_result = {31'b0, $signed(operand1) < $signed(operand2)};
            3'd3: alu_result = {31'b0, operand1 < operand2};
            3'd4: alu_result = operand1 ^ operand2;
            3'd5: begin
                if (subsra) alu_result = $signed(operand1) >>> operand2[4:0];
                else        alu_result = operand1 >> operand2[4:0];
            end
            3'd6: alu_result = operand1 | operand2;
            default: alu_result = operand1 & operand2;
        endcase
    end

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural meaning of one instruction, straight from the ISA rules
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] imm;
        logic [4:0]  sh;
        logic        alt;
        logic        ok;
        logic [31:0] r;
        imm = {{20{ins[31]}}, ins[31:20]};
        sh  = ins[24:20];
        alt = (ins[31:25] == 7'h20);
        ok  = 1'b0;
        r   = '0;
        if (ins[6:0] == 7'h33) begin
            ok = (ins[31:25] == 7'h00) || (alt && (ins[14:12] == 3'd0 || ins[14:12] == 3'd5));
            case (ins[14:12])
                3'd0: r = alt ? a - b : a + b;
                3'd1: r = a << b[4:0];
                3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: r = (a < b) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: begin
                    if (alt) r = $signed(a) >>> b[4:0];
                    else     r = a >> b[4:0];
                end
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end else if (ins[6:0] == 7'h13) begin
            ok = 1'b1;
            case (ins[14:12])
                3'd0: r = a + imm;
                3'd1: begin
                    ok = (ins[31:25] == 7'h00);
                    r  = a << sh;
                end
                3'd2: r = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
                3'd3: r = (a < imm) ? 32'd1 : 32'd0;
                3'd4: r = a ^ imm;
                3'd5: begin
                    ok = (ins[31:25] == 7'h00) || alt;
                    if (alt) r = $signed(a) >>> sh;
                    else     r = a >> sh;
                end
                3'd6: r = a | imm;
                default: r = a & imm;
            endcase
        end
        e.res = ok ? r : 32'd0;
        e.rd  = ins[11:7];
        e.ill = !ok;
        e.we  = ok && (ins[11:7] != 5'd0);
        return e;
    endfunction

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic step(output bit acc, output bit ofire);
        exp_t e;
        #1;
        acc   = in_valid && in_ready;
        ofire = out_valid && out_ready && !flush;
        if (flush) begin
            sb.delete();
        end else begin
            if (ofire) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_result", out_result, e.res);
                    check("sb_rd", 32'(out_rd), 32'(e.rd));
                    check("sb_we", 32'(out_we), 32'(e.we));
                    check("sb_illegal", 32'(out_illegal), 32'(e.ill));
                end
            end
            if (acc) sb.push_back(model(instr, rs1_val, rs2_val));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        bit acc, of;
        in_valid = 1'b1;
        instr    = ins;
        rs1_val  = a;
        rs2_val  = b;
        step(acc, of);
        in_valid = 1'b0;
        check("send_accepted", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        bit acc, of;
        for (int i = 0; i < n; i++) step(acc, of);
    endtask

    localparam logic [31:0] I_SUB   = 32'h402081B3;
    localparam logic [31:0] I_ADD   = 32'h002083B3;
    localparam logic [31:0] I_ADD0  = 32'h00208033;

    initial begin
        bit acc, of;
        int n_acc, n_out, first_out, last_out;
        logic [31:0] w;

        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_operand1", operand1, 32'd0);
        check("rst_operand2", operand2, 32'd0);
        check("rst_func3_subsra", {28'd0, func3, subsra}, 32'd0);
        check("rst_w_regs", {out_result[26:0], out_rd} | 32'(out_we) | 32'(out_illegal), 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // SUB
        send(I_SUB, 32'd32, 32'd30);
        check("sub_func3", 32'(func3), 32'd0);
        check("sub_subsra", 32'(subsra), 32'd1);
        check("sub_out_valid_early", 32'(out_valid), 32'd0);
        idle(1);
        check("sub_out_valid", 32'(out_valid), 32'd1);
        check("sub_result", out_result, 32'd2);
        check("sub_rd", 32'(out_rd), 32'd3);
        check("sub_we", 32'(out_we), 32'd1);
        idle(1);

        // ADDI negative immediate, then ADDI with imm[10] set
        send(32'hFFA08293, 32'd14, 32'd0);
        check("addi_op2", operand2, 32'hFFFFFFFA);
        check("addi_subsra", 32'(subsra), 32'd0);
        idle(1);
        check("addi_result", out_result, 32'd8);
        send(32'h40008093, 32'd5, 32'd0);
        check("addi400_subsra", 32'(subsra), 32'd0);
        idle(1);
        check("addi400_result", out_result, 32'd1029);

        // SRAI
        send(32'h4020D313, 32'hFFFFFFE8, 32'd0);
        check("srai_op2", operand2, 32'd2);
        check("srai_func3", 32'(func3), 32'd5);
        check("srai_subsra", 32'(subsra), 32'd1);
        idle(1);
        check("srai_result", out_result, 32'hFFFFFFFA);
        idle(1);

        // Backpressure: four ADDs, consumer stalled for three cycles
        n_acc = 0; n_out = 0; first_out = -1; last_out = -1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            out_ready = (cyc >= 3);
            in_valid  = (n_acc < 4);
            instr     = I_ADD;
            rs1_val   = 32'(n_acc * 10 + 1);
            rs2_val   = 32'(n_acc);
            #1;
            if (cyc == 2) begin
                check("bp_in_ready_low", 32'(in_ready), 32'd0);
                check("bp_accepts_before_stall", 32'(n_acc), 32'd2);
            end
            step(acc, of);
            if (acc) n_acc++;
            if (of) begin
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                n_out++;
            end
        end
        in_valid = 1'b0;
        check("bp_outputs", 32'(n_out), 32'd4);
        check("bp_back_to_back", 32'(last_out - first_out), 32'd3);

        // Illegal encodings and rd = x0
        out_ready = 1'b1;
        send(32'h020080B3, 32'd7, 32'd9);
        check("mul_alu_in", operand1 | operand2 | 32'(func3) | 32'(subsra), 32'd0);
        idle(1);
        check("mul_illegal", 32'(out_illegal), 32'd1);
        check("mul_we", 32'(out_we), 32'd0);
        check("mul_result", out_result, 32'd0);
        send(32'h0000007F, 32'd5, 32'd5);
        check("opc7f_alu_in", operand1 | operand2 | 32'(func3) | 32'(subsra), 32'd0);
        idle(1);
        check("opc7f_illegal", 32'(out_illegal), 32'd1);
        send(I_ADD0, 32'd3, 32'd4);
        idle(1);
        check("rd0_we", 32'(out_we), 32'd0);
        check("rd0_illegal", 32'(out_illegal), 32'd0);
        idle(1);

        // Reset with both stages full
        out_ready = 1'b0;
        send(I_ADD, 32'd1, 32'd1);
        send(I_ADD, 32'd2, 32'd2);
        check("full_before_reset", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_out_valid_immediate", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(I_SUB, 32'd32, 32'd30);
        check("post_reset_latency1", 32'(out_valid), 32'd0);
        idle(1);
        check("post_reset_valid", 32'(out_valid), 32'd1);
        check("post_reset_result", out_result, 32'd2);
        idle(1);

        // Flush with both stages full
        out_ready = 1'b0;
        send(I_ADD, 32'd5, 32'd6);
        send(I_ADD, 32'd7, 32'd8);
        flush    = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        step(acc, of);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        idle(1);
        check("flush_stays_empty", 32'(out_valid), 32'd0);
        send(I_SUB, 32'd100, 32'd1);
        idle(1);
        check("post_flush_valid", 32'(out_valid), 32'd1);
        check("post_flush_result", out_result, 32'd99);
        idle(1);

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 600; cyc++) begin
            w = $urandom;
            case ($urandom_range(0, 2))
                0: begin
                    w[6:0] = 7'h33;
                    case ($urandom_range(0, 3))
                        0, 1: w[31:25] = 7'h00;
                        2: w[31:25] = 7'h20;
                        default: ;
                    endcase
                end
                1: begin
                    w[6:0] = 7'h13;
                    if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                end
                default: ;
            endcase
            instr     = w;
            rs1_val   = $urandom;
            rs2_val   = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            step(acc, of);
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step(acc, of);
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
        check("drain_out_valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
